// File: rtl/stack_unit.sv
// Return-address stack sequencer: pushes a 16-bit address for JSR and pulls it
// back for RTS, one byte per cycle, inside a fixed 256-byte stack page.
module stack_unit #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] SP_RESET   = 8'hFD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jsr_start,
    input  logic        rts_start,
    input  logic [15:0] ret_addr,
    input  logic        sp_load,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] pc_addr,
    output logic        pc_load,
    output logic        busy,
    output logic [7:0]  sp
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_H,
        PUSH_L,
        PULL_L,
        PULL_H,
        RET
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  sp_q, sp_d;
    logic [15:0] ret_q, ret_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] pc_q, pc_d;

    logic [7:0]  sp_inc;
    logic [7:0]  sp_dec;
    logic [15:0] pulled_inc;

    // 8-bit sums keep the pointer wrapping inside the stack page.
    assign sp_inc     = sp_q + 8'd1;
    assign sp_dec     = sp_q - 8'd1;
    assign pulled_inc = {mem_rdata, lo_q} + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            ret_q   <= 16'h0000;
            lo_q    <= 8'h00;
            pc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ret_q   <= ret_d;
            lo_q    <= lo_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        sp_d      = sp_q;
        ret_d     = ret_q;
        lo_d      = lo_q;
        pc_d      = pc_q;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pc_load   = 1'b0;
        pc_addr   = pc_q;

        case (state_q)
            IDLE: begin
                if (jsr_start) begin
                    ret_d   = ret_addr;
                    state_d = PUSH_H;
                end else if (rts_start) begin
                    state_d = PULL_L;
                end else if (sp_load) begin
                    sp_d = sp_in;
                end
            end
            PUSH_H: begin
                mem_addr  = {STACK_PAGE, sp_q};
                mem_wdata = ret_q[15:8];
                mem_we    = 1'b1;
                sp_d      = sp_dec;
                state_d   = PUSH_L;
            end
            PUSH_L: begin
                mem_addr  = {STACK_PAGE, sp_q};
                mem_wdata = ret_q[7:0];
                mem_we    = 1'b1;
                sp_d      = sp_dec;
                state_d   = IDLE;
            end
            PULL_L: begin
                mem_addr = {STACK_PAGE, sp_inc};
                mem_re   = 1'b1;
                sp_d     = sp_inc;
                state_d  = PULL_H;
            end
            PULL_H: begin
                // Read data for the PULL_L strobe arrives this cycle.
                lo_d     = mem_rdata;
                mem_addr = {STACK_PAGE, sp_inc};
                mem_re   = 1'b1;
                sp_d     = sp_inc;
                state_d  = RET;
            end
            RET: begin
                pc_addr = pulled_inc;
                pc_d    = pulled_inc;
                pc_load = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign sp   = sp_q;

endmodule
